ahb_sram_bridge: RTL and testbench
==================================

// Module: ahb_sram_bridge
// PURPOSE
//  AHB-Lite slave fronting a single-port, byte-writable on-chip SRAM that the block infers internally.
//  Supports parametrised data width and depth, and HSIZE byte lanes.
//  Programmable read wait states and two-cycle ERROR responses for illegal transfers.
//  Forwards write data on back-to-back write->read to the same word.
//  Sits on the AHB interconnect as a generic RAM slave.
// PARAMETERS
//  HADDR_SIZE  32    address width
//  HDATA_SIZE  32    data width; 32 or 64; BE_SIZE = HDATA_SIZE/8
//  MEM_DEPTH   1024  words; power of 2; word addr = HADDR[$clog2(BE_SIZE) +: $clog2(MEM_DEPTH)]
//  RD_WAIT     0     read wait states, 0..3 (HREADYOUT low for RD_WAIT cycles of each read data phase)
// PORTS
//  HCLK       in   1           clock, all logic on rising edge
//  HRESET     in   1           synchronous, active-high reset
//  HSEL       in   1           slave select
//  HADDR      in   HADDR_SIZE  byte address
//  HWDATA     in   HDATA_SIZE  write data (data phase)
//  HRDATA     out  HDATA_SIZE  read data
//  HWRITE     in   1           1=write, 0=read
//  HSIZE      in   3           transfer size
//  HBURST     in   3           ignored; each beat is decoded from HADDR
//  HTRANS     in   2           IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  HREADY     in   1           bus ready; address phase is sampled only when high
//  HREADYOUT  out  1           slave ready
//  HRESP      out  1           0=OKAY, 1=ERROR
// BEHAVIOUR
//  Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE. Pending write is dropped. RAM contents are not cleared.
//  Valid address phase: HSEL & HREADY & HTRANS[1]. IDLE/BUSY/unselected transfers get a zero-wait OKAY.
//  Illegal transfer (no RAM access), any of:
//   - (1<<HSIZE) > BE_SIZE
//   - HADDR not aligned to (1<<HSIZE)
//   - word address >= MEM_DEPTH, i.e. any HADDR bit above the index is set
//  FSM states and transitions:
//   - IDLE:  valid write -> WDATA; valid read -> RWAIT (RD_WAIT>0) else RDATA; illegal -> ERR1.
//   - WDATA: HREADYOUT=1. At the end of the cycle, bytes of HWDATA selected by BE are written.
//            Next state is decoded from the concurrent address phase, same rules as IDLE.
//   - RWAIT: HREADYOUT=0, HRESP=0, cycle counter runs; after RD_WAIT cycles -> RDATA.
//   - RDATA: HREADYOUT=1, HRDATA valid; next state decoded as from IDLE.
//   - ERR1:  HREADYOUT=0, HRESP=1 -> ERR2.
//   - ERR2:  HREADYOUT=1, HRESP=1; next state decoded as from IDLE.
//  Byte enables: BE = ((1<<(1<<HSIZE))-1) << HADDR[$clog2(BE_SIZE)-1:0]. Registered at the address phase.
//  Read data path:
//   - RAM read is synchronous, issued on the address-phase clock edge.
//   - With RD_WAIT=0, data appears the next cycle with zero wait states.
//   - HRDATA=0 in every cycle that is not RDATA.
//   - HRDATA returns the full word regardless of HSIZE.
//  Contention: a read address phase that coincides with WDATA to the same word takes the written bytes
//   from that HWDATA (registered forward copy) and the remaining bytes from the RAM.
//   The resulting HRDATA is the post-write value. Different word: no forwarding.
//  Write followed by an illegal transfer: the write still commits.
//  An illegal transfer never modifies the RAM.
//  Reset asserted in WDATA: the write is not committed. Reset asserted in RWAIT/ERR1: transfer aborted,
//   HREADYOUT=1 the next cycle.
//  Throughput: back-to-back reads/writes with RD_WAIT=0 run at one beat per cycle, never stalling.
// TESTING
//  1. 32b, RD_WAIT=0: write 0xDEADBEEF @0x10 (WORD), then read @0x10
//     -> HRDATA=0xDEADBEEF one cycle after the read address phase; HREADYOUT stays 1.
//  2. Byte lanes: word @0x20=0x11223344; write BYTE 0xAA @0x21, then HWORD 0x5566 @0x22
//     -> read @0x20 returns 0x5566AA44.
//  3. Contention: WORD write 0x12345678 @0x40 immediately followed by a read @0x40, no idle
//     -> HRDATA=0x12345678 (not the stale word).
//  4. RD_WAIT=2: read @0x0 -> HREADYOUT low for exactly 2 cycles, then high with valid data.
//  5. Errors, each giving HRESP=1 for 2 cycles (HREADYOUT 0 then 1) with RAM unchanged:
//     - read @0x1002 with MEM_DEPTH=1024 (out of range)
//     - WORD write @0x3 (misaligned)
//     - DWORD on a 32b bus (size too large)
//  6. Reset during WDATA of a write 0xFFFFFFFF @0x8 (old value 0x0) -> after reset, read @0x8 = 0x0.
//     HREADYOUT=1 and HRESP=0 during reset.

Source files
------------

// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave in front of an inferred single-port byte-writable SRAM.
// Latency: writes commit at the end of the data phase; read data arrives RD_WAIT+1 cycles after the address phase.
// Backpressure: HREADYOUT drops for RD_WAIT cycles per read and for the first cycle of a two-cycle ERROR response.
module ahb_sram_bridge #(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32,
   parameter int MEM_DEPTH  = 1024,
   parameter int RD_WAIT    = 0
) (
   input  logic                  HCLK_i,
   input  logic                  HRESET_i,
   input  logic                  HSEL_i,
   input  logic [HADDR_SIZE-1:0] HADDR_i,
   input  logic [HDATA_SIZE-1:0] HWDATA_i,
   output logic [HDATA_SIZE-1:0] HRDATA_o,
   input  logic                  HWRITE_i,
   input  logic [2:0]            HSIZE_i,
   input  logic [2:0]            HBURST_i,
   input  logic [1:0]            HTRANS_i,
   input  logic                  HREADY_i,
   output logic                  HREADYOUT_o,
   output logic                  HRESP_o
);

   localparam int BE_SIZE = HDATA_SIZE / 8;
   localparam int BO_W    = $clog2(BE_SIZE);
   localparam int IDX_W   = $clog2(MEM_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_WDATA, S_RWAIT, S_RDATA, S_ERR1, S_ERR2} state_t;

   // Write context captured at the address phase, used during the data phase.
   typedef struct packed {
      logic [IDX_W-1:0]   idx;
      logic [BE_SIZE-1:0] be;
   } wr_ctl_t;

   state_t                state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   wr_ctl_t               wr_q;
   logic [BE_SIZE-1:0]    fwd_be_q;
   logic [HDATA_SIZE-1:0] fwd_dat_q;
   logic [HDATA_SIZE-1:0] rd_dat_q;
   logic [HDATA_SIZE-1:0] mem_q [MEM_DEPTH];
   logic [HDATA_SIZE-1:0] rd_merged;

   logic [BO_W-1:0]    byte_off;
   logic [IDX_W-1:0]   addr_idx;
   logic [7:0]         size_mask;
   logic [7:0]         lane_base;
   logic [BE_SIZE-1:0] be_addr;
   logic               access, illegal, acc_wr, acc_rd, acc_err, mem_we;
   logic               unused_ok;

   // HBURST is irrelevant (each beat decodes its own address); HTRANS[0] only separates NONSEQ/SEQ.
   assign unused_ok = ^{HBURST_i, HTRANS_i[0]};

   assign byte_off  = HADDR_i[BO_W-1:0];
   assign addr_idx  = HADDR_i[BO_W +: IDX_W];
   assign size_mask = (8'd1 << HSIZE_i) - 8'd1;
   assign access    = HSEL_i & HREADY_i & HTRANS_i[1] & HREADYOUT_o;
   assign illegal   = (HSIZE_i > 3'(BO_W))
                    | (|(byte_off & size_mask[BO_W-1:0]))
                    | (|HADDR_i[HADDR_SIZE-1:BO_W+IDX_W]);
   assign acc_wr    = access & ~illegal & HWRITE_i;
   assign acc_rd    = access & ~illegal & ~HWRITE_i;
   assign acc_err   = access & illegal;
   // A reset landing in the write data phase discards that write.
   assign mem_we    = (state_q == S_WDATA) & ~HRESET_i;

   // Lane mask for the transfer size, before shifting to the byte offset.
   always_comb begin
      lane_base = 8'hFF;
      case (HSIZE_i)
         3'd0:    lane_base = 8'h01;
         3'd1:    lane_base = 8'h03;
         3'd2:    lane_base = 8'h0F;
         default: lane_base = 8'hFF;
      endcase
   end

   assign be_addr = lane_base[BE_SIZE-1:0] << byte_off;

   // Next-state decode; every ready state decodes the concurrent address phase the same way.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_RWAIT: begin
            if (cnt_q == 2'(RD_WAIT - 1)) state_d = S_RDATA;
            else                          cnt_d   = cnt_q + 2'd1;
         end
         S_ERR1:  state_d = S_ERR2;
         default: begin
            cnt_d = '0;
            if (acc_err)     state_d = S_ERR1;
            else if (acc_wr) state_d = S_WDATA;
            else if (acc_rd) state_d = (RD_WAIT > 0) ? S_RWAIT : S_RDATA;
            else             state_d = S_IDLE;
         end
      endcase
   end

   // Control registers: FSM, wait counter, write context and forwarding lane mask.
   always_ff @(posedge HCLK_i) begin
      if (HRESET_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         wr_q     <= '0;
         fwd_be_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (acc_wr) wr_q <= '{idx: addr_idx, be: be_addr};
         // The RAM read at this edge misses the write committing at the same edge.
         if (acc_rd) fwd_be_q <= ((state_q == S_WDATA) && (wr_q.idx == addr_idx)) ? wr_q.be : '0;
      end
   end

   // SRAM array: byte-masked write in the data phase, synchronous read at the address phase.
   always_ff @(posedge HCLK_i) begin
      if (mem_we) begin
         for (int b = 0; b < BE_SIZE; b++) begin
            if (wr_q.be[b]) mem_q[wr_q.idx][8*b +: 8] <= HWDATA_i[8*b +: 8];
         end
      end
      if (acc_rd) begin
         rd_dat_q  <= mem_q[addr_idx];
         fwd_dat_q <= HWDATA_i;
      end
   end

   // Merge forwarded write bytes over the RAM word.
   always_comb begin
      rd_merged = rd_dat_q;
      for (int b = 0; b < BE_SIZE; b++) begin
         if (fwd_be_q[b]) rd_merged[8*b +: 8] = fwd_dat_q[8*b +: 8];
      end
   end

   assign HREADYOUT_o = !((state_q == S_RWAIT) || (state_q == S_ERR1));
   assign HRESP_o     = (state_q == S_ERR1) || (state_q == S_ERR2);
   assign HRDATA_o    = (state_q == S_RDATA) ? rd_merged : '0;

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Testbench for ahb_sram_bridge: one zero-wait instance and one RD_WAIT=2 instance.
// Latency: expectations are queued at the address phase and retired when the data phase completes.
// Backpressure: the address phase is held while the selected slave drives HREADYOUT low.
module tb_ahb_sram_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel0, sel1, hwrite;
   logic [31:0] haddr, hwdata;
   logic [2:0]  hsize, hburst;
   logic [1:0]  htrans;
   logic [31:0] rdata0, rdata1;
   logic        ro0, ro1, resp0, resp1;
   int          cur;
   logic        obs_rdy, obs_resp;
   logic [31:0] obs_rdata;

   typedef struct {
      string       tag;
      logic        err;
      logic        rd;
      logic [31:0] rdata;
      int          waits;
   } exp_t;

   exp_t        exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] pend_wdata;

   always #5 clk = ~clk;

   ahb_sram_bridge #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(1024), .RD_WAIT(0)) dut0 (
      .HCLK_i(clk), .HRESET_i(rst), .HSEL_i(sel0), .HADDR_i(haddr), .HWDATA_i(hwdata),
      .HRDATA_o(rdata0), .HWRITE_i(hwrite), .HSIZE_i(hsize), .HBURST_i(hburst),
      .HTRANS_i(htrans), .HREADY_i(ro0), .HREADYOUT_o(ro0), .HRESP_o(resp0));

   ahb_sram_bridge #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(1024), .RD_WAIT(2)) dut1 (
      .HCLK_i(clk), .HRESET_i(rst), .HSEL_i(sel1), .HADDR_i(haddr), .HWDATA_i(hwdata),
      .HRDATA_o(rdata1), .HWRITE_i(hwrite), .HSIZE_i(hsize), .HBURST_i(hburst),
      .HTRANS_i(htrans), .HREADY_i(ro1), .HREADYOUT_o(ro1), .HRESP_o(resp1));

   assign obs_rdy   = (cur == 1) ? ro1    : ro0;
   assign obs_resp  = (cur == 1) ? resp1  : resp0;
   assign obs_rdata = (cur == 1) ? rdata1 : rdata0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // One bus cycle (plus any stall): drive an address phase, retire the previous data phase.
   task automatic xfer(input logic vld, input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [31:0] wdat, input logic err, input logic [31:0] rexp, input string tag);
      exp_t e;
      int   n_prev;
      int   w;
      logic done;
      n_prev = exp_q.size();
      sel0   = vld && (cur == 0);
      sel1   = vld && (cur == 1);
      htrans = vld ? 2'b10 : 2'b00;
      hwrite = wr;
      hsize  = sz;
      haddr  = addr;
      hwdata = pend_wdata;
      if (vld) begin
         e.tag   = tag;
         e.err   = err;
         e.rd    = !wr;
         e.rdata = rexp;
         e.waits = err ? 1 : ((!wr && cur == 1) ? 2 : 0);
         exp_q.push_back(e);
      end
      w    = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (n_prev == 0) begin
            done = 1'b1;
         end else if (obs_rdy === 1'b1) begin
            e = exp_q.pop_front();
            check({e.tag, " waits"}, 32'(w), 32'(e.waits));
            check({e.tag, " hresp"}, {31'd0, obs_resp}, {31'd0, e.err});
            check({e.tag, " hrdata"}, obs_rdata, (e.rd && !e.err) ? e.rdata : 32'd0);
            done = 1'b1;
         end else begin
            w++;
            check({exp_q[0].tag, " stall hresp"}, {31'd0, obs_resp}, {31'd0, exp_q[0].err});
            check({exp_q[0].tag, " stall hrdata"}, obs_rdata, 32'd0);
            if (w > 6) begin
               check({exp_q[0].tag, " ready timeout"}, {31'd0, obs_rdy}, 32'd1);
               void'(exp_q.pop_front());
               done = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      pend_wdata = (vld && wr) ? wdat : 32'd0;
   endtask

   task automatic idle();
      xfer(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0, "idle");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; cur = 0; sel0 = 1'b0; sel1 = 1'b0; hwrite = 1'b0; haddr = '0;
      hwdata = '0; hsize = 3'd2; hburst = 3'd0; htrans = 2'b00; pend_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst0 hreadyout", {31'd0, ro0}, 32'd1);
      check("rst0 hresp", {31'd0, resp0}, 32'd0);
      check("rst0 hrdata", rdata0, 32'd0);
      check("rst1 hreadyout", {31'd0, ro1}, 32'd1);
      check("rst1 hresp", {31'd0, resp1}, 32'd0);
      check("rst1 hrdata", rdata1, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Plain write then read, zero wait states.
      xfer(1, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0, "t1_wr");
      idle();
      xfer(1, 0, 3'd2, 32'h10, 0, 0, 32'hDEADBEEF, "t1_rd");
      idle();

      // Byte lanes; junk in unselected lanes must be masked off.
      xfer(1, 1, 3'd2, 32'h20, 32'h11223344, 0, 0, "t2_wr_word");
      xfer(1, 1, 3'd0, 32'h21, 32'hFFFFAAFF, 0, 0, "t2_wr_byte");
      xfer(1, 1, 3'd1, 32'h22, 32'h55661234, 0, 0, "t2_wr_hword");
      xfer(1, 0, 3'd2, 32'h20, 0, 0, 32'h5566AA44, "t2_rd_word");
      xfer(1, 0, 3'd0, 32'h21, 0, 0, 32'h5566AA44, "t2_rd_byte");
      idle();

      // Write->read contention on the same word, and no forwarding across words.
      xfer(1, 1, 3'd2, 32'h48, 32'hA0A0B0B0, 0, 0, "t3_wr_other");
      idle();
      xfer(1, 1, 3'd2, 32'h40, 32'h12345678, 0, 0, "t3_wr");
      xfer(1, 0, 3'd2, 32'h40, 0, 0, 32'h12345678, "t3_rd_fwd");
      xfer(1, 1, 3'd2, 32'h44, 32'h99999999, 0, 0, "t3_wr_diff");
      xfer(1, 0, 3'd2, 32'h48, 0, 0, 32'hA0A0B0B0, "t3_rd_nofwd");
      xfer(1, 0, 3'd2, 32'h44, 0, 0, 32'h99999999, "t3_rd_b2b");
      idle();

      // Illegal transfers: two-cycle ERROR, RAM untouched, preceding write still commits.
      xfer(1, 1, 3'd2, 32'h0, 32'h0BADC0DE, 0, 0, "t5_wr0");
      xfer(1, 1, 3'd2, 32'h4, 32'hCAFE0004, 0, 0, "t5_wr4");
      xfer(1, 1, 3'd2, 32'h3, 32'hFFFFFFFF, 1, 0, "t5_err_misalign");
      xfer(1, 0, 3'd1, 32'h1002, 0, 1, 0, "t5_err_range");
      xfer(1, 1, 3'd3, 32'h0, 32'hFFFFFFFF, 1, 0, "t5_err_size");
      xfer(1, 0, 3'd2, 32'h4, 0, 0, 32'hCAFE0004, "t5_rd4");
      xfer(1, 0, 3'd2, 32'h0, 0, 0, 32'h0BADC0DE, "t5_rd0");
      idle();

      // Reset in the data phase of a write drops that write.
      xfer(1, 1, 3'd2, 32'h8, 32'h00000000, 0, 0, "t6_wr_old");
      xfer(1, 1, 3'd2, 32'h8, 32'hFFFFFFFF, 0, 0, "t6_wr_new");
      rst = 1'b1; sel0 = 1'b0; htrans = 2'b00; hwdata = pend_wdata;
      @(negedge clk);
      check("t6 rst hreadyout", {31'd0, ro0}, 32'd1);
      check("t6 rst hresp", {31'd0, resp0}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      pend_wdata = '0;
      xfer(1, 0, 3'd2, 32'h8, 0, 0, 32'h00000000, "t6_rd");
      idle();

      // Wait-state instance.
      cur = 1;
      xfer(1, 1, 3'd2, 32'h0, 32'hA5A50001, 0, 0, "t4_wr");
      idle();
      xfer(1, 0, 3'd2, 32'h0, 0, 0, 32'hA5A50001, "t4_rd");
      xfer(1, 1, 3'd2, 32'h4, 32'h77778888, 0, 0, "t4_wr_fwd");
      xfer(1, 0, 3'd2, 32'h4, 0, 0, 32'h77778888, "t4_rd_fwd");
      xfer(1, 0, 3'd1, 32'h1002, 0, 1, 0, "t4_err_range");
      xfer(1, 0, 3'd2, 32'h0, 0, 0, 32'hA5A50001, "t4_rd_again");
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
